cmd_status_arbiter: RTL and testbench

- Shares one command/status bus (master side of the command/status bus interface) between N requesters.
- Each requester has its own command channel and status channel.
- Commands are accepted by round-robin arbitration, registered, and then issued on the bus.
- Each issued command records its requester index in an in-order tracking FIFO, and the bus status stream is routed back to the requester at the FIFO head.
- Sits between per-client command/status ports and a single slave-side bus instance.

---
 rtl/cmd_status_arbiter_pkg.sv | 40 ++++
 rtl/cmd_order_fifo.sv | 66 ++++++
 rtl/cmd_status_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_cmd_status_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_status_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cmd_status_arbiter_pkg
// Shared types for the command/status bus and its requester-side arbiter.
//   Command     : bus command encoding (WRITE/READ)
//   Status      : bus status encoding (OK/ERROR)
//   ARB_MAX_N   : largest requester count the arbiter supports
//   CmdArbState : command FSM states
//   req_idx_t   : requester index, wide enough for ARB_MAX_N requesters
// ----------------------------------------------------------------------------
package cmd_status_arbiter_pkg;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } Command;

    typedef enum logic {
        OK    = 1'b0,
        ERROR = 1'b1
    } Status;

    localparam int ARB_MAX_N = 8;
    localparam int ARB_IDX_W = $clog2(ARB_MAX_N);

    typedef logic [ARB_IDX_W-1:0] req_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } CmdArbState;

    // Index following cur in a ring of n requesters.
    function automatic req_idx_t next_idx(input req_idx_t cur, input int n);
        if (int'(cur) >= n - 1) begin
            return '0;
        end
        return cur + 1'b1;
    endfunction

endpackage

// File: rtl/cmd_order_fifo.sv
// ----------------------------------------------------------------------------
// cmd_order_fifo
// In-order FIFO of requester indices, one entry per command that has been
// accepted but whose status has not yet come back. DEPTH must be a power of
// two and at least 2.
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write push_idx at the tail (ignored when full)
//   push_idx  : requester index to record
//   pop       : drop the head entry (ignored when empty)
//   head      : requester index at the head
//   empty     : no entries
//   full      : DEPTH entries
//   count     : number of entries, 0..DEPTH
// ----------------------------------------------------------------------------
module cmd_order_fifo
    import cmd_status_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  req_idx_t                 push_idx,
    input  logic                     pop,
    output req_idx_t                 head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    req_idx_t     mem [DEPTH];
    // Pointers carry one bit beyond the address so full and empty differ.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_idx;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cmd_status_arbiter.sv
// ----------------------------------------------------------------------------
// cmd_status_arbiter
// Shares one command/status bus between N requesters. Commands are accepted
// round-robin, registered, then issued on the bus; each accepted command's
// requester index is queued in order so the returning status stream is routed
// combinationally to the requester whose command is oldest.
//   i_clk, i_rst              : clock, asynchronous active-high reset
//   i_req_command_valid/ready : per-requester command handshake
//   i_req_command             : per-requester command bit (Command)
//   o_req_status_valid/ready  : per-requester status handshake
//   o_req_status              : per-requester status bit (Status)
//   o_bus_command_valid/ready : bus command handshake, o_bus_command payload
//   i_bus_status_valid/ready  : bus status handshake, i_bus_status payload
//   o_outstanding             : accepted commands without returned status
//   o_err_count               : saturating count of delivered ERROR statuses
//   o_orphan                  : sticky, bus status seen with nothing pending
// ----------------------------------------------------------------------------
module cmd_status_arbiter
    import cmd_status_arbiter_pkg::*;
#(
    parameter int N         = 2,
    parameter int DEPTH     = 4,
    parameter int ERR_WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N-1:0]             i_req_command_valid,
    output logic [N-1:0]             o_req_command_ready,
    input  logic [N-1:0]             i_req_command,
    output logic [N-1:0]             o_req_status_valid,
    input  logic [N-1:0]             i_req_status_ready,
    output logic [N-1:0]             o_req_status,
    output logic                     o_bus_command_valid,
    input  logic                     i_bus_command_ready,
    output logic                     o_bus_command,
    input  logic                     i_bus_status_valid,
    output logic                     o_bus_status_ready,
    input  logic                     i_bus_status,
    output logic [$clog2(DEPTH):0]   o_outstanding,
    output logic [ERR_WIDTH-1:0]     o_err_count,
    output logic                     o_orphan
);

    CmdArbState             state_q;
    CmdArbState             state_d;
    req_idx_t               rr_q;
    req_idx_t               rr_d;
    req_idx_t               win_q;
    req_idx_t               win_d;
    Command                 cmd_q;
    Command                 cmd_d;
    logic [ERR_WIDTH-1:0]   err_q;
    logic                   orphan_q;

    logic                   grant_found;
    req_idx_t               grant_idx;

    logic                   fifo_push;
    logic                   fifo_pop;
    req_idx_t               fifo_head;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [$clog2(DEPTH):0] fifo_count;

    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Round-robin search: first valid requester at or after rr_q, wrapping.
    // rr_q < N, so exactly one of the two comparisons hits for each offset.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int off = 0; off < N; off++) begin
            for (int i = 0; i < N; i++) begin
                if (!grant_found && i_req_command_valid[i] &&
                    ((i == int'(rr_q) + off) || (i == int'(rr_q) + off - N))) begin
                    grant_found = 1'b1;
                    grant_idx   = req_idx_t'(i);
                end
            end
        end
    end

    // Command FSM. The full check uses the pre-pop count, so a pop in the
    // same cycle never opens a slot early.
    always_comb begin
        state_d             = state_q;
        rr_d                = rr_q;
        win_d               = win_q;
        cmd_d               = cmd_q;
        fifo_push           = 1'b0;
        o_req_command_ready = '0;
        o_bus_command_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found && !fifo_full && !i_rst) begin
                    for (int i = 0; i < N; i++) begin
                        if (grant_idx == req_idx_t'(i)) begin
                            o_req_command_ready[i] = 1'b1;
                            cmd_d                  = Command'(i_req_command[i]);
                        end
                    end
                    fifo_push = 1'b1;
                    win_d     = grant_idx;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                o_bus_command_valid = 1'b1;
                if (i_bus_command_ready) begin
                    rr_d    = next_idx(win_q, N);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_bus_command = cmd_q;

    // Status path: only the requester at the FIFO head sees the bus status.
    always_comb begin
        o_req_status_valid = '0;
        o_req_status       = '0;
        o_bus_status_ready = 1'b0;
        if (!fifo_empty) begin
            for (int i = 0; i < N; i++) begin
                if (fifo_head == req_idx_t'(i)) begin
                    o_bus_status_ready    = i_req_status_ready[i];
                    o_req_status_valid[i] = i_bus_status_valid;
                    o_req_status[i]       = i_bus_status;
                end
            end
        end
    end

    // Ready is already low when the FIFO is empty.
    assign fifo_pop = o_bus_status_ready && i_bus_status_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            win_q    <= '0;
            cmd_q    <= WRITE;
            err_q    <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
            if (fifo_pop && (i_bus_status == ERROR)) begin
                err_q <= sat_inc(err_q);
            end
            if (fifo_empty && i_bus_status_valid) begin
                orphan_q <= 1'b1;
            end
        end
    end

    cmd_order_fifo #(
        .DEPTH (DEPTH)
    ) u_order_fifo (
        .clk      (i_clk),
        .rst      (i_rst),
        .push     (fifo_push),
        .push_idx (win_d),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    assign o_outstanding = fifo_count;
    assign o_err_count   = err_q;
    assign o_orphan      = orphan_q;

endmodule

// File: tb/tb_cmd_status_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cmd_status_arbiter
// Drives directed then random traffic into a 3-requester arbiter. A reference
// model (queues + round-robin pointer) predicts grants, routing and counters
// every cycle and queues the expected bus commands and delivered statuses; a
// separate monitor pops those queues whenever the DUT shows a handshake.
// ----------------------------------------------------------------------------
module tb_cmd_status_arbiter;
    import cmd_status_arbiter_pkg::*;

    localparam int N         = 3;
    localparam int DEPTH     = 4;
    localparam int ERR_WIDTH = 2;
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int ERR_MAX   = (1 << ERR_WIDTH) - 1;
    localparam logic [N-1:0] ALL = '1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_cv, req_cr, req_cmd, req_sv, req_sr, req_st;
    logic                 bus_cv, bus_cr, bus_cmd, bus_sv, bus_sr, bus_st;
    logic [CW-1:0]        outst;
    logic [ERR_WIDTH-1:0] errc;
    logic                 orphan;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_ord[$];        // requester index per outstanding command, oldest first
    int exp_cmd_q[$];    // commands expected on the bus, in order
    int exp_sidx_q[$];   // requester expected to receive each delivered status
    int exp_sst_q[$];    // status value expected with it
    bit m_busy;
    int m_rr, m_w, m_err;
    bit m_orphan;

    always #5 clk = ~clk;

    cmd_status_arbiter #(
        .N         (N),
        .DEPTH     (DEPTH),
        .ERR_WIDTH (ERR_WIDTH)
    ) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_req_command_valid (req_cv),
        .o_req_command_ready (req_cr),
        .i_req_command       (req_cmd),
        .o_req_status_valid  (req_sv),
        .i_req_status_ready  (req_sr),
        .o_req_status        (req_st),
        .o_bus_command_valid (bus_cv),
        .i_bus_command_ready (bus_cr),
        .o_bus_command       (bus_cmd),
        .i_bus_status_valid  (bus_sv),
        .o_bus_status_ready  (bus_sr),
        .i_bus_status        (bus_st),
        .o_outstanding       (outst),
        .o_err_count         (errc),
        .o_orphan            (orphan)
    );

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic bit have();
        return m_ord.size() > 0;
    endfunction

    // Reference model: evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        int gnt, h, idx, exp_rdy, exp_sv, exp_st;
        if (rst) begin
            m_ord.delete();
            exp_cmd_q.delete();
            exp_sidx_q.delete();
            exp_sst_q.delete();
            m_busy = 0; m_rr = 0; m_w = 0; m_err = 0; m_orphan = 0;
            chk("rst_bus_valid", int'(bus_cv), 0);
            chk("rst_bus_cmd", int'(bus_cmd), int'(WRITE));
            chk("rst_cmd_ready", int'(req_cr), 0);
            chk("rst_status_valid", int'(req_sv), 0);
            chk("rst_outstanding", int'(outst), 0);
            chk("rst_err_count", int'(errc), 0);
            chk("rst_orphan", int'(orphan), 0);
        end else begin
            gnt = -1;
            if (!m_busy && m_ord.size() < DEPTH) begin
                for (int off = 0; off < N; off++) begin
                    idx = (m_rr + off) % N;
                    if (gnt < 0 && ((int'(req_cv) >> idx) & 1) == 1) gnt = idx;
                end
            end
            exp_rdy = (gnt >= 0) ? (1 << gnt) : 0;
            chk("cmd_ready", int'(req_cr), exp_rdy);
            chk("bus_valid", int'(bus_cv), int'(m_busy));
            chk("outstanding", int'(outst), m_ord.size());
            chk("err_count", int'(errc), m_err);
            chk("orphan", int'(orphan), int'(m_orphan));

            h = have() ? m_ord[0] : -1;
            exp_sv = (h >= 0 && bus_sv) ? (1 << h) : 0;
            exp_st = (h >= 0 && bus_st) ? (1 << h) : 0;
            chk("status_valid", int'(req_sv), exp_sv);
            chk("status_value", int'(req_st), exp_st);
            chk("bus_status_ready", int'(bus_sr), (h >= 0) ? ((int'(req_sr) >> h) & 1) : 0);

            if (h >= 0 && bus_sv && ((int'(req_sr) >> h) & 1) == 1) begin
                exp_sidx_q.push_back(h);
                exp_sst_q.push_back(int'(bus_st));
                void'(m_ord.pop_front());
                if (bus_st == ERROR && m_err < ERR_MAX) m_err++;
            end else if (h < 0 && bus_sv) begin
                m_orphan = 1;
            end
            if (m_busy && bus_cr) begin
                m_busy = 0;
                m_rr   = (m_w + 1) % N;
            end
            if (gnt >= 0) begin
                m_busy = 1;
                m_w    = gnt;
                m_ord.push_back(gnt);
                exp_cmd_q.push_back((int'(req_cmd) >> gnt) & 1);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a transfer.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (bus_cv) begin
                if (exp_cmd_q.size() == 0) begin
                    chk("bus_cmd_unexpected", 1, 0);
                end else begin
                    chk("bus_cmd", int'(bus_cmd), exp_cmd_q[0]);
                    if (bus_cr) void'(exp_cmd_q.pop_front());
                end
            end
            for (int k = 0; k < N; k++) begin
                if (req_sv[k] && req_sr[k]) begin
                    if (exp_sidx_q.size() == 0) begin
                        chk("status_unexpected", k, -1);
                    end else begin
                        chk("status_route", k, exp_sidx_q[0]);
                        chk("status_data", int'(req_st[k]), exp_sst_q[0]);
                        void'(exp_sidx_q.pop_front());
                        void'(exp_sst_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input logic [N-1:0] cv, input logic [N-1:0] cmd,
                        input logic [N-1:0] sr, input logic cr,
                        input logic sv, input logic st);
        req_cv  = cv;
        req_cmd = cmd;
        req_sr  = sr;
        bus_cr  = cr;
        bus_sv  = sv;
        bus_st  = st;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic rsv;
        rst = 1'b1;
        step('0, '0, '0, 1'b0, 1'b0, OK);
        step('0, '0, '0, 1'b0, 1'b0, OK);
        rst = 1'b0;

        // Single requester READ then OK status
        step(N'(1), N'(1), ALL, 1'b1, 1'b0, OK);
        chk("single_outstanding", int'(outst), 1);
        chk("single_bus_valid", int'(bus_cv), 1);
        chk("single_bus_cmd", int'(bus_cmd), int'(READ));
        step('0, '0, ALL, 1'b1, 1'b0, OK);
        step('0, '0, ALL, 1'b1, 1'b1, OK);
        chk("single_drained", int'(outst), 0);

        // Contention between requesters 0 and 1, status returned at once
        repeat (12) step(N'(3), N'($urandom), ALL, 1'b1, have(), OK);

        // Backpressure on the bus command
        step(ALL, N'($urandom), ALL, 1'b0, 1'b0, OK);
        repeat (5) step(ALL, N'($urandom), ALL, 1'b0, 1'b0, OK);
        step(ALL, N'($urandom), ALL, 1'b1, 1'b0, OK);

        // Fill to DEPTH, then pop alone, then pop alongside an accept
        repeat (12) step(ALL, N'($urandom), ALL, 1'b1, 1'b0, OK);
        chk("full_outstanding", int'(outst), DEPTH);
        step(ALL, N'($urandom), ALL, 1'b1, 1'b1, OK);
        chk("pop_only_outstanding", int'(outst), DEPTH - 1);
        step(ALL, N'($urandom), ALL, 1'b1, 1'b1, OK);
        chk("push_pop_outstanding", int'(outst), DEPTH - 1);

        // Drain, then stalled ERROR, then saturation
        repeat (10) step('0, '0, ALL, 1'b1, have(), OK);
        chk("drained", int'(outst), 0);
        step(N'(2), ALL, ALL, 1'b1, 1'b0, OK);
        step('0, '0, ALL, 1'b1, 1'b0, OK);
        repeat (3) step('0, '0, '0, 1'b1, 1'b1, ERROR);
        chk("err_stalled", int'(errc), 0);
        step('0, '0, ALL, 1'b1, 1'b1, ERROR);
        chk("err_first", int'(errc), 1);
        for (int c = 0; c < 30; c++) begin
            step(ALL, N'($urandom), (c % 3 == 0) ? '0 : ALL, 1'b1, have(), ERROR);
        end
        chk("err_saturated", int'(errc), ERR_MAX);

        // Orphan status with nothing outstanding
        repeat (10) step('0, '0, ALL, 1'b1, have(), OK);
        step('0, '0, ALL, 1'b1, 1'b1, OK);
        step('0, '0, ALL, 1'b1, 1'b0, OK);
        chk("orphan_set", int'(orphan), 1);

        // Reset while a command waits in ISSUE
        step(N'(1), N'(1), ALL, 1'b0, 1'b0, OK);
        step('0, '0, ALL, 1'b0, 1'b0, OK);
        chk("issue_before_reset", int'(bus_cv), 1);
        rst = 1'b1;
        #1;
        chk("reset_bus_valid", int'(bus_cv), 0);
        chk("reset_outstanding", int'(outst), 0);
        chk("reset_orphan", int'(orphan), 0);
        step('0, '0, '0, 1'b0, 1'b0, OK);
        step('0, '0, '0, 1'b0, 1'b0, OK);
        rst = 1'b0;

        // Random traffic
        repeat (600) begin
            rsv = have() ? ($urandom % 4 != 0) : ($urandom % 32 == 0);
            step(N'($urandom), N'($urandom), N'($urandom), 1'($urandom), rsv, 1'($urandom));
        end
        repeat (2) step('0, '0, '0, 1'b0, 1'b0, OK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
